// File: rtl/axis_rr_arbiter_pkg.sv
// Shared definitions for the AXI4-Stream round-robin arbiter family.
//   arb_state_t  : arbiter FSM encoding (idle / locked to one packet)
//   AXIS_DATA_W  : default stream data width
//   arb_clog2    : index width helper, never narrower than one bit
package axis_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  localparam int AXIS_DATA_W = 8;

  // A one-bit index is still needed for two sources, so the result is
  // clamped to at least 1.
  function automatic int arb_clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// Ports:
//   req      [N_SRC-1:0] : request vector
//   last_ptr [IDX_W-1:0] : most recently served index
//   winner   [IDX_W-1:0] : first set request searching upward from last_ptr+1
//   any_req              : at least one request present
module rr_pick
  import axis_rr_arbiter_pkg::*;
#(
  parameter int N_SRC = 4,
  localparam int IDX_W = arb_clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] last_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Walk the candidates starting just after the last served source; the
  // last one visited is last_ptr itself, so it only wins when alone.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = IDX_W'((int'(last_ptr) + k) % N_SRC);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: per-packet round-robin N:1 AXI4-Stream arbiter with a
// zero-latency grant-controlled mux.
// Ports:
//   clk, resetn           : clock, asynchronous active-low reset
//   s_tdata/tvalid/tlast  : flattened source streams (source i at i*DATA_W)
//   s_tready              : per-source ready, only the granted source sees m_tready
//   m_tdata/tvalid/tlast  : shared downstream stream, m_tready its ready
//   grant_idx             : current or most recently granted source
//   busy                  : high while a packet holds the grant
// Optional: define AXIS_ARB_TID_EN to add m_tid (source id of the
// packet in flight, 0 when idle).
module axis_rr_arbiter
  import axis_rr_arbiter_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int DATA_W = AXIS_DATA_W,
  localparam int IDX_W = arb_clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [N_SRC*DATA_W-1:0] s_tdata,
  input  logic [N_SRC-1:0]        s_tvalid,
  input  logic [N_SRC-1:0]        s_tlast,
  output logic [N_SRC-1:0]        s_tready,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
`ifdef AXIS_ARB_TID_EN
  output logic [IDX_W-1:0]        m_tid,
`endif
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    busy
);

  arb_state_t       state, next_state;
  logic [IDX_W-1:0] last_ptr, next_last_ptr, next_grant;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic [DATA_W-1:0] src_data [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign src_data[i] = s_tdata[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N_SRC (N_SRC)
  ) u_pick (
    .req      (s_tvalid),
    .last_ptr (last_ptr),
    .winner   (winner),
    .any_req  (any_req)
  );

  // Reset forces IDLE immediately, which in turn closes the mux below in
  // the same cycle, so outputs drop with no clock needed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      last_ptr  <= IDX_W'(N_SRC - 1);
    end else begin
      state     <= next_state;
      grant_idx <= next_grant;
      last_ptr  <= next_last_ptr;
    end
  end

  // Datapath mux: only the locked source is connected. m_tvalid depends
  // on state and s_tvalid only, never on m_tready.
  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state == ST_LOCKED) begin
      m_tdata             = src_data[grant_idx];
      m_tvalid            = s_tvalid[grant_idx];
      m_tlast             = s_tlast[grant_idx];
      s_tready[grant_idx] = m_tready;
    end
  end

  // Grant is taken in IDLE and released only by a completed tlast beat;
  // stalls and competing requests leave it untouched.
  always_comb begin
    next_state    = state;
    next_grant    = grant_idx;
    next_last_ptr = last_ptr;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          next_grant = winner;
          next_state = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (m_tvalid && m_tready && m_tlast) begin
          next_last_ptr = grant_idx;
          next_state    = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_LOCKED);

`ifdef AXIS_ARB_TID_EN
  assign m_tid = (state == ST_LOCKED) ? grant_idx : '0;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter (N_SRC=4, DATA_W=8): a vector table
// for reset release, fairness and a single-requester packet, then
// hand-written sequences for stall, backpressure and reset mid-packet.
module tb_axis_rr_arbiter;

  logic        clk;
  logic        resetn;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tlast;
  logic [3:0]  s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
`ifdef AXIS_ARB_TID_EN
  logic [1:0]  m_tid;
`endif
  logic [1:0]  grant_idx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  axis_rr_arbiter #(
    .N_SRC  (4),
    .DATA_W (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
`ifdef AXIS_ARB_TID_EN
    .m_tid     (m_tid),
`endif
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        tready;
    logic        exp_mvalid;
    logic        exp_mlast;
    logic [7:0]  exp_data;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_grant;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] data, input logic [3:0] valid,
                              input logic [3:0] last, input logic tready,
                              input logic mv, input logic ml, input logic [7:0] md,
                              input logic [3:0] rdy, input logic [1:0] g,
                              input logic b);
    vec_t v;
    v.data = data; v.valid = valid; v.last = last; v.tready = tready;
    v.exp_mvalid = mv; v.exp_mlast = ml; v.exp_data = md;
    v.exp_ready = rdy; v.exp_grant = g; v.exp_busy = b;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    s_tdata  = v.data;
    s_tvalid = v.valid;
    s_tlast  = v.last;
    m_tready = v.tready;
  endtask

  task automatic checkOutput(input vec_t v, input int row);
    string tag;
    tag = $sformatf("row%0d", row);
    check({tag, ".m_tvalid"}, m_tvalid, v.exp_mvalid);
    check({tag, ".s_tready"}, s_tready, v.exp_ready);
    check({tag, ".grant_idx"}, grant_idx, v.exp_grant);
    check({tag, ".busy"}, busy, v.exp_busy);
    if (v.exp_mvalid) begin
      check({tag, ".m_tdata"}, m_tdata, v.exp_data);
      check({tag, ".m_tlast"}, m_tlast, v.exp_mlast);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [31:0] DF = 32'h44434241;
  localparam logic [3:0]  F  = 4'b1111;

  logic bp_pat [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int beat;
    int cyc;
    logic [7:0] b;

    // Fairness: 2-beat packets from every source, one IDLE cycle between.
    vecs.push_back(mk(DF, F, 4'b0000, 1, 0, 0, 8'h00, 4'b0000, 0, 0));
    vecs.push_back(mk(DF, F, 4'b0000, 1, 1, 0, 8'h41, 4'b0001, 0, 1));
    vecs.push_back(mk(DF, F, 4'b0001, 1, 1, 1, 8'h41, 4'b0001, 0, 1));
    vecs.push_back(mk(DF, F, 4'b0000, 1, 0, 0, 8'h00, 4'b0000, 0, 0));
    vecs.push_back(mk(DF, F, 4'b0000, 1, 1, 0, 8'h42, 4'b0010, 1, 1));
    vecs.push_back(mk(DF, F, 4'b0010, 1, 1, 1, 8'h42, 4'b0010, 1, 1));
    vecs.push_back(mk(DF, F, 4'b0000, 1, 0, 0, 8'h00, 4'b0000, 1, 0));
    vecs.push_back(mk(DF, F, 4'b0000, 1, 1, 0, 8'h43, 4'b0100, 2, 1));
    vecs.push_back(mk(DF, F, 4'b0100, 1, 1, 1, 8'h43, 4'b0100, 2, 1));
    vecs.push_back(mk(DF, F, 4'b0000, 1, 0, 0, 8'h00, 4'b0000, 2, 0));
    vecs.push_back(mk(DF, F, 4'b0000, 1, 1, 0, 8'h44, 4'b1000, 3, 1));
    vecs.push_back(mk(DF, F, 4'b1000, 1, 1, 1, 8'h44, 4'b1000, 3, 1));
    vecs.push_back(mk(DF, F, 4'b0000, 1, 0, 0, 8'h00, 4'b0000, 3, 0));
    vecs.push_back(mk(DF, F, 4'b0000, 1, 1, 0, 8'h41, 4'b0001, 0, 1));
    vecs.push_back(mk(DF, F, 4'b0001, 1, 1, 1, 8'h41, 4'b0001, 0, 1));
    vecs.push_back(mk(DF, F, 4'b0000, 1, 0, 0, 8'h00, 4'b0000, 0, 0));
    vecs.push_back(mk(DF, F, 4'b0000, 1, 1, 0, 8'h42, 4'b0010, 1, 1));
    vecs.push_back(mk(DF, F, 4'b0010, 1, 1, 1, 8'h42, 4'b0010, 1, 1));
    // Single requester: source 2 sends A1, A2, A3.
    vecs.push_back(mk(32'h00A10000, 4'b0100, 4'b0000, 1, 0, 0, 8'h00, 4'b0000, 1, 0));
    vecs.push_back(mk(32'h00A10000, 4'b0100, 4'b0000, 1, 1, 0, 8'hA1, 4'b0100, 2, 1));
    vecs.push_back(mk(32'h00A20000, 4'b0100, 4'b0000, 1, 1, 0, 8'hA2, 4'b0100, 2, 1));
    vecs.push_back(mk(32'h00A30000, 4'b0100, 4'b0100, 1, 1, 1, 8'hA3, 4'b0100, 2, 1));
    vecs.push_back(mk(32'h00000000, 4'b0000, 4'b0000, 1, 0, 0, 8'h00, 4'b0000, 2, 0));

    // Reset held with every source requesting.
    resetn   = 1'b0;
    s_tdata  = DF;
    s_tvalid = F;
    s_tlast  = 4'b0000;
    m_tready = 1'b1;
    tick();
    tick();
    #4;
    check("reset.m_tvalid", m_tvalid, 1'b0);
    check("reset.s_tready", s_tready, 4'b0000);
    check("reset.grant_idx", grant_idx, 2'd0);
    check("reset.busy", busy, 1'b0);
`ifdef AXIS_ARB_TID_EN
    check("reset.m_tid", m_tid, 2'd0);
`endif
    tick();
    resetn = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #4;
      checkOutput(vecs[i], i);
      tick();
    end

    // Source stall: source 0 pauses 5 cycles after its first beat.
    s_tdata = 32'h000000C1; s_tvalid = 4'b0001; s_tlast = 4'b0000; m_tready = 1'b1;
    #4;
    check("stall.idle_busy", busy, 1'b0);
    tick();
    #4;
    check("stall.beat1_valid", m_tvalid, 1'b1);
    check("stall.beat1_data", m_tdata, 8'hC1);
    check("stall.beat1_grant", grant_idx, 2'd0);
    tick();
    s_tvalid = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      #4;
      check($sformatf("stall.hold%0d_busy", k), busy, 1'b1);
      check($sformatf("stall.hold%0d_grant", k), grant_idx, 2'd0);
      check($sformatf("stall.hold%0d_valid", k), m_tvalid, 1'b0);
      tick();
    end
    s_tdata = 32'h000000C2; s_tvalid = 4'b0001; s_tlast = 4'b0001;
    #4;
    check("stall.resume_valid", m_tvalid, 1'b1);
    check("stall.resume_data", m_tdata, 8'hC2);
    check("stall.resume_last", m_tlast, 1'b1);
    tick();
    s_tvalid = 4'b0000; s_tlast = 4'b0000;
    #4;
    check("stall.done_busy", busy, 1'b0);

    // Backpressure on source 1's 4-beat packet; source 3 requests mid-packet.
    s_tdata = 32'h0000B000; s_tvalid = 4'b0010; m_tready = 1'b1;
    tick();
    beat = 0;
    cyc = 0;
    while (beat < 4 && cyc < 30) begin
      b = 8'(8'hB0 + beat);
      m_tready = bp_pat[cyc % 10];
      s_tdata  = {8'hD0, 8'h00, b, 8'h00};
      s_tlast  = {3'b000, 1'(beat == 3), 1'b0};
      s_tvalid = {1'(cyc >= 1), 3'b010};
      #4;
      check($sformatf("bp.c%0d_grant", cyc), grant_idx, 2'd1);
      check($sformatf("bp.c%0d_valid", cyc), m_tvalid, 1'b1);
      check($sformatf("bp.c%0d_data", cyc), m_tdata, b);
      check($sformatf("bp.c%0d_last", cyc), m_tlast, 1'(beat == 3));
      check($sformatf("bp.c%0d_ready1", cyc), s_tready[1], m_tready);
      check($sformatf("bp.c%0d_ready3", cyc), s_tready[3], 1'b0);
      if (m_tready) beat++;
      cyc++;
      tick();
    end
    check("bp.beats_done", beat, 4);
    check("bp.cycles", cyc, 8);

    // Source 3 takes over; reset lands mid-packet.
    s_tvalid = 4'b1000; s_tlast = 4'b0000; s_tdata = 32'hD0000000; m_tready = 1'b1;
    #4;
    check("tid.idle_busy", busy, 1'b0);
    check("tid.idle_grant", grant_idx, 2'd1);
    tick();
    #4;
    check("tid.lock_grant", grant_idx, 2'd3);
    check("tid.lock_valid", m_tvalid, 1'b1);
    check("tid.lock_data", m_tdata, 8'hD0);
`ifdef AXIS_ARB_TID_EN
    check("tid.lock_tid", m_tid, 2'd3);
`endif
    tick();
    s_tdata = 32'hD1000000;
    #2;
    resetn = 1'b0;
    #1;
    check("rstmid.m_tvalid", m_tvalid, 1'b0);
    check("rstmid.busy", busy, 1'b0);
    check("rstmid.grant_idx", grant_idx, 2'd0);
    check("rstmid.s_tready", s_tready, 4'b0000);
`ifdef AXIS_ARB_TID_EN
    check("rstmid.m_tid", m_tid, 2'd0);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
